// File: rtl/user_event_arbiter.sv
// user_event_arbiter: merges keyboard event strobes and push-button levels
// (with auto-repeat on left/right/down) into a small event FIFO. The game
// FSM reads that FIFO through the user_event / ready / rd_req handshake.
module user_event_arbiter #(
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_DELAY   = 25_000_000,
    parameter int REPEAT_PERIOD  = 5_000_000,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [2:0]                        kbd_event_i,
    input  logic                              kbd_event_valid_i,
    input  logic [4:0]                        btn_i,
    output logic [2:0]                        user_event_o,
    output logic                              user_event_ready_o,
    input  logic                              user_event_rd_req_i,
    output logic [DROP_CNT_WIDTH-1:0]         drop_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o
);
    // Event codes shared with the game FSM.
    localparam logic [2:0] EV_LEFT     = 3'd1;
    localparam logic [2:0] EV_RIGHT    = 3'd2;
    localparam logic [2:0] EV_DOWN     = 3'd3;
    localparam logic [2:0] EV_ROTATE   = 3'd4;
    localparam logic [2:0] EV_NEW_GAME = 3'd5;

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int DW1  = DROP_CNT_WIDTH + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_e;

    rpt_e              rpt_q  [3];
    logic [CW-1:0]     rcnt_q [3];
    logic [4:0]        btn_q;
    logic              armed_q;
    logic [4:0]        btn_pend_q, btn_pend_d;
    logic              kbd_pend_q, kbd_pend_d;
    logic [2:0]        kbd_code_q;
    logic              rr_q;                // 0: keyboard preferred, 1: buttons
    logic [2:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     count_q;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic [4:0] btn_rise, btn_set, btn_mask;
    logic [2:0] rpt_fire, btn_code, gnt_code;
    logic       gnt_kbd, gnt_btn, gnt_valid;
    logic       full, empty, pop, push, flush, fifo_drop, kbd_drop;
    logic [1:0] drop_inc;
    logic [DW1-1:0] drop_sum;

    // The first cycle after reset only loads history, so a button already
    // held through reset needs a fresh press before it generates events.
    assign btn_rise = armed_q ? (btn_i & ~btn_q) : 5'b0;

    // Repeat pulses for the three movement buttons.
    always_comb begin
        rpt_fire = '0;
        for (int k = 0; k < 3; k++) begin
            if (btn_i[k] && rpt_q[k] == RPT_DELAY && rcnt_q[k] == CW'(REPEAT_DELAY - 1))
                rpt_fire[k] = 1'b1;
            if (btn_i[k] && rpt_q[k] == RPT_REPEAT && rcnt_q[k] == CW'(REPEAT_PERIOD - 1))
                rpt_fire[k] = 1'b1;
        end
    end

    assign btn_set = btn_rise | {2'b00, rpt_fire};

    // Button offer: new game first, otherwise lowest pending index.
    always_comb begin
        btn_mask = '0;
        btn_code = '0;
        if (btn_pend_q[4]) begin
            btn_mask = 5'b10000;
            btn_code = EV_NEW_GAME;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (btn_pend_q[i]) begin
                    btn_mask = 5'b00001 << i;
                    btn_code = 3'(i + 1);
                end
            end
        end
    end

    // Round-robin between the two requesters, one grant per cycle.
    always_comb begin
        gnt_kbd = 1'b0;
        gnt_btn = 1'b0;
        if (kbd_pend_q && (|btn_pend_q)) begin
            gnt_kbd = ~rr_q;
            gnt_btn = rr_q;
        end else begin
            gnt_kbd = kbd_pend_q;
            gnt_btn = |btn_pend_q;
        end
    end

    assign gnt_valid = gnt_kbd | gnt_btn;
    assign gnt_code  = gnt_kbd ? kbd_code_q : btn_code;

    assign empty     = (count_q == '0);
    assign full      = (count_q == LW'(FIFO_DEPTH));
    assign pop       = user_event_rd_req_i & ~empty;
    assign flush     = gnt_valid & (gnt_code == EV_NEW_GAME);
    assign push      = gnt_valid & ~flush & (~full | pop);
    assign fifo_drop = gnt_valid & ~flush & full & ~pop;
    assign kbd_drop  = kbd_event_valid_i & kbd_pend_q & ~gnt_kbd;

    // A new set in the grant cycle wins over the clear.
    assign kbd_pend_d = (kbd_pend_q & ~gnt_kbd) | kbd_event_valid_i;
    assign btn_pend_d = (btn_pend_q & ~(gnt_btn ? btn_mask : 5'b0)) | btn_set;

    assign drop_inc   = {1'b0, kbd_drop} + {1'b0, fifo_drop};
    assign drop_sum   = {1'b0, drop_cnt_q} + DW1'(drop_inc);
    assign drop_cnt_d = drop_sum[DW1-1] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];

    // Button history and per-bit auto-repeat state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            btn_q   <= '0;
            armed_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                rpt_q[k]  <= RPT_IDLE;
                rcnt_q[k] <= '0;
            end
        end else begin
            btn_q   <= btn_i;
            armed_q <= 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (!btn_i[k]) begin
                    rpt_q[k]  <= RPT_IDLE;
                    rcnt_q[k] <= '0;
                end else begin
                    case (rpt_q[k])
                        RPT_IDLE: if (btn_rise[k]) begin
                            rpt_q[k]  <= RPT_DELAY;
                            rcnt_q[k] <= '0;
                        end
                        RPT_DELAY: if (rpt_fire[k]) begin
                            rpt_q[k]  <= RPT_REPEAT;
                            rcnt_q[k] <= '0;
                        end else begin
                            rcnt_q[k] <= rcnt_q[k] + 1'b1;
                        end
                        RPT_REPEAT: rcnt_q[k] <= rpt_fire[k] ? '0 : rcnt_q[k] + 1'b1;
                        default: rpt_q[k] <= RPT_IDLE;
                    endcase
                end
            end
        end
    end

    // Pending flags, keyboard code and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            kbd_pend_q <= 1'b0;
            kbd_code_q <= '0;
            btn_pend_q <= '0;
            rr_q       <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            kbd_pend_q <= kbd_pend_d;
            btn_pend_q <= btn_pend_d;
            drop_cnt_q <= drop_cnt_d;
            if (kbd_event_valid_i) kbd_code_q <= kbd_event_i;
            if (gnt_valid) rr_q <= gnt_kbd;
        end
    end

    // Event FIFO; a granted new-game event flushes and restarts it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            mem_q[0] <= EV_NEW_GAME;
            rd_ptr_q <= '0;
            wr_ptr_q <= AW'(1);
            count_q  <= LW'(1);
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= gnt_code;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + LW'(push) - LW'(pop);
        end
    end

    assign user_event_ready_o = ~empty;
    assign user_event_o       = empty ? 3'd0 : mem_q[rd_ptr_q];
    assign fifo_level_o       = count_q;
    assign drop_cnt_o         = drop_cnt_q;

endmodule

// File: tb/tb_user_event_arbiter.sv
// Bench for user_event_arbiter: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle against a queue-based model.
module tb_user_event_arbiter;
    localparam int DEPTH = 4;
    localparam int D     = 10;
    localparam int P     = 4;
    localparam int DW    = 3;
    localparam int DMAX  = (1 << DW) - 1;
    localparam int LEFT = 1, RIGHT = 2, DOWN = 3, ROT = 4, NG = 5;

    logic          clk_i = 0;
    logic          rst_n_i = 0;
    logic [2:0]    kbd_event_i = 0;
    logic          kbd_event_valid_i = 0;
    logic [4:0]    btn_i = 0;
    logic [2:0]    user_event_o;
    logic          user_event_ready_o;
    logic          user_event_rd_req_i = 0;
    logic [DW-1:0] drop_cnt_o;
    logic [2:0]    fifo_level_o;

    user_event_arbiter #(.FIFO_DEPTH(DEPTH), .REPEAT_DELAY(D), .REPEAT_PERIOD(P),
                         .DROP_CNT_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .kbd_event_i(kbd_event_i),
        .kbd_event_valid_i(kbd_event_valid_i), .btn_i(btn_i),
        .user_event_o(user_event_o), .user_event_ready_o(user_event_ready_o),
        .user_event_rd_req_i(user_event_rd_req_i), .drop_cnt_o(drop_cnt_o),
        .fifo_level_o(fifo_level_o));

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   mq[$];
    bit   mkp;
    int   mkc;
    bit   mbp[5];
    bit   mrr;          // 1: buttons have the next turn on a tie
    int   mdrop;
    bit   mprev[5];
    bit   marmed;
    int   mh[3];
    bit   mact[3];

    function automatic void m_reset();
        mq.delete();
        mkp = 0; mkc = 0; mrr = 0; mdrop = 0; marmed = 0;
        for (int i = 0; i < 5; i++) begin mbp[i] = 0; mprev[i] = 0; end
        for (int i = 0; i < 3; i++) begin mh[i] = 0; mact[i] = 0; end
    endfunction

    function automatic void m_step(bit kv, int kc, logic [4:0] b, bit rd);
        bit gk = 0, gb = 0, anyb = 0;
        int bsel = -1, code = 0, ndrop = 0;
        bit set[5];
        for (int i = 0; i < 5; i++) anyb |= mbp[i];
        if (mbp[4]) bsel = 4;
        else for (int i = 3; i >= 0; i--) if (mbp[i]) bsel = i;
        if (mkp && anyb) begin gb = mrr; gk = !mrr; end
        else begin gk = mkp; gb = anyb; end
        if (gk) code = mkc;
        if (gb) code = bsel + 1;
        if (gk || gb) mrr = gk;
        if ((gk || gb) && code == NG) begin
            mq.delete();
            mq.push_back(NG);
        end else begin
            if (rd && mq.size() > 0) void'(mq.pop_front());
            if (gk || gb) begin
                if (mq.size() < DEPTH) mq.push_back(code);
                else ndrop++;
            end
        end
        if (kv && mkp && !gk) ndrop++;
        mkp = (mkp && !gk) || kv;
        if (kv) mkc = kc;
        for (int k = 0; k < 5; k++) begin
            bit rise = marmed && b[k] && !mprev[k];
            set[k] = rise;
            if (k < 3) begin
                if (!b[k]) mact[k] = 0;
                else if (rise) begin mact[k] = 1; mh[k] = 0; end
                else if (mact[k]) begin
                    mh[k]++;
                    if (mh[k] == D || (mh[k] > D && (mh[k] - D) % P == 0)) set[k] = 1;
                end
            end
        end
        for (int k = 0; k < 5; k++) mbp[k] = (mbp[k] && !(gb && bsel == k)) || set[k];
        mdrop = (mdrop + ndrop > DMAX) ? DMAX : mdrop + ndrop;
        for (int k = 0; k < 5; k++) mprev[k] = b[k];
        marmed = 1;
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) m_reset();
        else m_step(kbd_event_valid_i, int'(kbd_event_i), btn_i, user_event_rd_req_i);
    end

    // Per-cycle comparison against the model.
    always @(posedge clk_i) begin
        #1;
        if (rst_n_i) begin
            chk("ready", int'(user_event_ready_o), int'(mq.size() > 0));
            chk("level", int'(fifo_level_o), mq.size());
            chk("drop_cnt", int'(drop_cnt_o), mdrop);
            if (mq.size() > 0) chk("head", int'(user_event_o), mq[0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    bit auto_rd = 0;
    int cyc = 0;
    int log_code[$];
    int log_cyc[$];

    task automatic nxt();
        @(negedge clk_i);
        cyc++;
        kbd_event_valid_i = 0;
        if (auto_rd) begin
            user_event_rd_req_i = user_event_ready_o;
            if (user_event_ready_o) begin
                log_code.push_back(int'(user_event_o));
                log_cyc.push_back(cyc);
            end
        end else begin
            user_event_rd_req_i = 0;
        end
    endtask

    task automatic do_reset();
        rst_n_i = 0;
        btn_i = 0;
        nxt(); nxt();
        rst_n_i = 1;
    endtask

    task automatic kstrobe(input int c);
        kbd_event_valid_i = 1;
        kbd_event_i = 3'(c);
    endtask

    task automatic pop_check(input string nm, input int exp_head);
        user_event_rd_req_i = 1;
        nxt();
        chk(nm, int'(user_event_o), exp_head);
    endtask

    initial begin
        int seq[6];
        seq = '{LEFT, RIGHT, DOWN, ROT, LEFT, RIGHT};

        // Reset values
        do_reset();
        chk("rst_ready", int'(user_event_ready_o), 0);
        chk("rst_event", int'(user_event_o), 0);
        chk("rst_level", int'(fifo_level_o), 0);
        chk("rst_drop", int'(drop_cnt_o), 0);

        // Single keyboard event: ready two edges after the strobe
        nxt(); kstrobe(LEFT);
        nxt();
        chk("kbd_not_yet", int'(user_event_ready_o), 0);
        nxt();
        chk("kbd_ready", int'(user_event_ready_o), 1);
        chk("kbd_head", int'(user_event_o), LEFT);
        user_event_rd_req_i = 1;
        nxt();
        chk("kbd_pop_ready", int'(user_event_ready_o), 0);
        chk("kbd_pop_level", int'(fifo_level_o), 0);

        // Round-robin: two back-to-back simultaneous pairs
        do_reset();
        nxt(); kstrobe(ROT); btn_i = 5'b00010;
        nxt(); kstrobe(DOWN); btn_i = 5'b01010;
        nxt(); nxt(); nxt(); nxt();
        chk("rr_level", int'(fifo_level_o), 4);
        chk("rr_head0", int'(user_event_o), ROT);
        pop_check("rr_head1", RIGHT);
        pop_check("rr_head2", DOWN);
        pop_check("rr_head3", ROT);
        user_event_rd_req_i = 1;
        nxt();
        chk("rr_empty", int'(user_event_ready_o), 0);
        btn_i = 0;

        // Overflow, drop counting and saturation
        do_reset();
        nxt();
        for (int i = 0; i < 6; i++) begin kstrobe(seq[i]); nxt(); nxt(); end
        nxt();
        chk("ovf_level", int'(fifo_level_o), 4);
        chk("ovf_drop", int'(drop_cnt_o), 2);
        chk("ovf_head", int'(user_event_o), LEFT);
        for (int i = 0; i < 6; i++) begin kstrobe(DOWN); nxt(); nxt(); end
        nxt();
        chk("drop_sat", int'(drop_cnt_o), DMAX);

        // New game flush from a FIFO holding three events
        user_event_rd_req_i = 1;
        nxt();
        chk("ng_pre_level", int'(fifo_level_o), 3);
        btn_i = 5'b10000;
        nxt(); nxt();
        chk("ng_level", int'(fifo_level_o), 1);
        chk("ng_head", int'(user_event_o), NG);
        chk("ng_drop", int'(drop_cnt_o), DMAX);
        btn_i = 0;
        nxt();

        // Auto-repeat on down; rotate never repeats
        do_reset();
        auto_rd = 1;
        log_code.delete(); log_cyc.delete();
        nxt(); btn_i = 5'b00100;
        repeat (30) nxt();
        btn_i = 0;
        repeat (20) nxt();
        chk("rpt_count", log_code.size(), 6);
        if (log_code.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("rpt_code", log_code[i], DOWN);
            chk("rpt_gap0", log_cyc[1] - log_cyc[0], D);
            for (int i = 2; i < 6; i++) chk("rpt_gapn", log_cyc[i] - log_cyc[i-1], P);
        end
        log_code.delete(); log_cyc.delete();
        btn_i = 5'b01000;
        repeat (30) nxt();
        btn_i = 0;
        repeat (10) nxt();
        chk("rot_count", log_code.size(), 1);
        if (log_code.size() == 1) chk("rot_code", log_code[0], ROT);
        auto_rd = 0;

        // Asynchronous reset mid-repeat with a full FIFO
        do_reset();
        nxt(); btn_i = 5'b00001;
        for (int i = 0; i < 8; i++) begin kstrobe(RIGHT); nxt(); end
        repeat (6) nxt();
        chk("pre_rst_level", int'(fifo_level_o), 4);
        #3 rst_n_i = 0;
        #1;
        chk("arst_ready", int'(user_event_ready_o), 0);
        chk("arst_event", int'(user_event_o), 0);
        chk("arst_level", int'(fifo_level_o), 0);
        chk("arst_drop", int'(drop_cnt_o), 0);
        nxt(); nxt();
        rst_n_i = 1;
        auto_rd = 1;
        log_code.delete(); log_cyc.delete();
        repeat (40) nxt();
        chk("held_after_rst", log_code.size(), 0);
        btn_i = 0; nxt(); nxt();
        btn_i = 5'b00001; repeat (4) nxt();
        btn_i = 0; repeat (4) nxt();
        chk("repress_count", log_code.size(), 1);
        if (log_code.size() == 1) chk("repress_code", log_code[0], LEFT);
        auto_rd = 0;

        // Randomized traffic checked by the per-cycle model compare
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            nxt();
            if ($urandom_range(2) == 0) kstrobe($urandom_range(LEFT, NG - 1));
            if ($urandom_range(40) == 0) kstrobe(NG);
            user_event_rd_req_i = ($urandom_range(2) == 0);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(23) == 0) btn_i[k] = ~btn_i[k];
            if ($urandom_range(199) == 0) btn_i[4] = ~btn_i[4];
        end
        btn_i = 0;
        repeat (5) nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
